// File: rtl/wr_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Option: WR_ARB_PKT_LOCK_EN (see wr_arbiter.sv).
package wr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int NREQ_DEF   = 4;
  localparam int DWIDTH_DEF = 8;

endpackage

// File: rtl/wr_arbiter_rr_pick.sv
// Rotating-priority selector: first request at or after rr_ptr+1.
// Pure combinational; wr_arbiter registers its result.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] j;

  // Walk farthest-first so the nearest candidate wins.
  always_comb begin
    valid = |req;
    index = '0;
    j     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((int'(rr_ptr) + k) % NREQ);
      if (req[j]) index = j;
    end
  end

endmodule

// File: rtl/wr_arbiter.sv
// Round-robin write arbiter feeding one FIFO write port.
// Define WR_ARB_PKT_LOCK_EN to hold the grant until req_last.
module wr_arbiter
  import wr_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic                     wclk,
  input  logic                     wrstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     wfull,
  output logic                     wpush,
  output logic [DWIDTH-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          acc;
  logic          rel;
  logic [DWIDTH-1:0] own_data;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign own_data = req_data[int'(owner_q)*DWIDTH +: DWIDTH];
  assign acc      = (state_q == BUSY) & req[owner_q] & ~wfull;

`ifdef WR_ARB_PKT_LOCK_EN
  assign rel = acc & req_last[owner_q];
`else
  // Single-beat mode: release on any accepted beat or a dropped request.
  logic unused_last;
  assign unused_last = ^req_last;
  assign rel = acc | ~req[owner_q];
`endif

  always_comb begin
    gnt          = '0;
    gnt[owner_q] = acc;
    wpush        = acc;
    wdata        = acc ? own_data : '0;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          owner_d = pick_idx;
        end
      end
      BUSY: begin
        if (rel) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == BUSY);

endmodule
